// File: rtl/aesop_tkr_pkg.sv
// Shared definitions for the AESOP tracker ASIC data receivers: word width,
// header field layout and the receiver state encoding.
package aesop_tkr_pkg;

  localparam int ASIC_WORD_W = 12;

  // Header word: [11:8] chip address, [7:4] cluster count, [3:2] event tag, [1:0] ASIC errors
  localparam int HDR_ADDR_LSB  = 8;
  localparam int HDR_ADDR_W    = 4;
  localparam int HDR_NCLUS_LSB = 4;
  localparam int HDR_NCLUS_W   = 4;
  localparam int HDR_TAG_LSB   = 2;
  localparam int HDR_TAG_W     = 2;
  localparam int HDR_ERR_LSB   = 0;
  localparam int HDR_ERR_W     = 2;

  // Cluster word: [11:6] cluster width minus one, [5:0] first strip
  localparam int CLUS_WIDTH_LSB = 6;
  localparam int CLUS_WIDTH_W   = 6;
  localparam int CLUS_STRIP_LSB = 0;
  localparam int CLUS_STRIP_W   = 6;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    CLUS
  } asic_rx_state_t;

  // Odd parity: the data bits plus the parity bit must hold an odd number of ones.
  function automatic logic oddParityOk(input logic [ASIC_WORD_W-1:0] word,
                                       input logic                   parBit);
    return ^{word, parBit};
  endfunction

endpackage

// File: rtl/asic_rx_fifo.sv
// Single-clock word FIFO for one ASIC receiver; count-based Full/Valid, head word
// presented from storage so a written word is visible only from the next cycle.
module asic_rx_fifo #(
  parameter int DEPTH  = 64,
  parameter int DATA_W = 12
) (
  input  logic              SysCLK,
  input  logic              ResetN,
  input  logic              WrEn,
  input  logic [DATA_W-1:0] WrData,
  input  logic              RdEn,
  output logic [DATA_W-1:0] Dout,
  output logic              Valid,
  output logic              Full,
  output logic              WrDrop
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wrPtr;
  logic [PTR_W-1:0]  rdPtr;
  logic [CNT_W-1:0]  count;
  logic              push;
  logic              pop;

  // A pop on a full FIFO frees the slot the concurrent write lands in.
  always_comb begin
    Valid  = (count != '0);
    Full   = (count == CNT_W'(DEPTH));
    pop    = RdEn && Valid;
    push   = WrEn && (!Full || pop);
    WrDrop = WrEn && Full && !pop;
    Dout   = Valid ? mem[rdPtr] : '0;
  end

  always_ff @(posedge SysCLK) begin
    if (push) mem[wrPtr] <= WrData;
  end

  always_ff @(posedge SysCLK or negedge ResetN) begin
    if (!ResetN) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + PTR_W'(1);
      if (pop)  rdPtr <= rdPtr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/asic_data_rx.sv
// Serial hit-data receiver for one tracker ASIC line: deserializes frames into
// 12-bit words and queues them. Define ASIC_RX_PARITY_EN for per-word odd parity.
module asic_data_rx
  import aesop_tkr_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic                   SysCLK,
  input  logic                   ResetN,
  input  logic                   Enable,
  input  logic                   SerIn,
  input  logic [3:0]             ChipAddr,
  input  logic                   RdEn,
  input  logic                   ClrErr,
  output logic [ASIC_WORD_W-1:0] Dout,
  output logic                   Valid,
  output logic                   Full,
  output logic                   Busy,
  output logic                   FrameDone,
  output logic                   Overflow,
  output logic                   ParErr,
  output logic                   AddrErr
);

`ifdef ASIC_RX_PARITY_EN
  localparam int         SHIFT_W  = ASIC_WORD_W;
  localparam logic [3:0] LAST_BIT = 4'(ASIC_WORD_W);
`else
  localparam int         SHIFT_W  = ASIC_WORD_W - 1;
  localparam logic [3:0] LAST_BIT = 4'(ASIC_WORD_W - 1);
`endif

  asic_rx_state_t         state;
  logic [3:0]             bitCnt;
  logic [HDR_NCLUS_W-1:0] clusLeft;
  logic [HDR_NCLUS_W-1:0] nClus;
  logic [SHIFT_W-1:0]     shiftReg;
  logic [ASIC_WORD_W-1:0] wordNow;
  logic [ASIC_WORD_W-1:0] wrData_p0;
  logic                   wrEn_p0;
  logic                   wordEnd;
  logic                   hdrEnd;
  logic                   doShift;
  logic                   addrBad;
  logic                   wrDrop;

  // Without parity the last data bit is taken straight from SerIn so the word is
  // complete on the edge that samples it; with parity that edge samples the parity bit.
  always_comb begin
`ifdef ASIC_RX_PARITY_EN
    wordNow = shiftReg;
    doShift = (bitCnt != LAST_BIT);
`else
    wordNow = {shiftReg, SerIn};
    doShift = 1'b1;
`endif
    wordEnd = (state != IDLE) && (bitCnt == LAST_BIT);
    hdrEnd  = (state == HDR) && wordEnd;
    nClus   = wordNow[HDR_NCLUS_LSB +: HDR_NCLUS_W];
    addrBad = hdrEnd && (wordNow[HDR_ADDR_LSB +: HDR_ADDR_W] != ChipAddr);
  end

  assign Busy = (state != IDLE);

  always_ff @(posedge SysCLK) begin
    if (doShift) shiftReg <= {shiftReg[SHIFT_W-2:0], SerIn};
    if (wordEnd) wrData_p0 <= wordNow;
  end

  always_ff @(posedge SysCLK or negedge ResetN) begin
    if (!ResetN) begin
      state     <= IDLE;
      bitCnt    <= '0;
      clusLeft  <= '0;
      wrEn_p0   <= 1'b0;
      FrameDone <= 1'b0;
      AddrErr   <= 1'b0;
    end else begin
      wrEn_p0   <= wordEnd;
      FrameDone <= 1'b0;
      AddrErr   <= addrBad | (AddrErr & ~ClrErr);
      case (state)
        IDLE: begin
          bitCnt <= '0;
          if (SerIn && Enable) state <= HDR;
        end
        HDR: begin
          if (wordEnd) begin
            bitCnt   <= '0;
            clusLeft <= nClus;
            if (nClus == '0) begin
              state     <= IDLE;
              FrameDone <= 1'b1;
            end else begin
              state <= CLUS;
            end
          end else begin
            bitCnt <= bitCnt + 4'd1;
          end
        end
        CLUS: begin
          if (wordEnd) begin
            bitCnt   <= '0;
            clusLeft <= clusLeft - 4'd1;
            if (clusLeft == 4'd1) begin
              state     <= IDLE;
              FrameDone <= 1'b1;
            end
          end else begin
            bitCnt <= bitCnt + 4'd1;
          end
        end
        default: begin
          state  <= IDLE;
          bitCnt <= '0;
        end
      endcase
    end
  end

  // ---- stage p0 -> FIFO: captured word enters storage one cycle after capture
  asic_rx_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (ASIC_WORD_W)
  ) u_fifo (
    .SysCLK (SysCLK),
    .ResetN (ResetN),
    .WrEn   (wrEn_p0),
    .WrData (wrData_p0),
    .RdEn   (RdEn),
    .Dout   (Dout),
    .Valid  (Valid),
    .Full   (Full),
    .WrDrop (wrDrop)
  );

  always_ff @(posedge SysCLK or negedge ResetN) begin
    if (!ResetN) Overflow <= 1'b0;
    else         Overflow <= wrDrop | (Overflow & ~ClrErr);
  end

`ifdef ASIC_RX_PARITY_EN
  always_ff @(posedge SysCLK or negedge ResetN) begin
    if (!ResetN) ParErr <= 1'b0;
    else         ParErr <= (wordEnd && !oddParityOk(shiftReg, SerIn)) | (ParErr & ~ClrErr);
  end
`else
  assign ParErr = 1'b0;
`endif

endmodule

// File: tb/tb_asic_data_rx.sv
// Directed bench for asic_data_rx (DEPTH=16); honours ASIC_RX_PARITY_EN when defined.
`timescale 1ns/1ps
module tb_asic_data_rx;

  logic        SysCLK = 1'b0;
  logic        ResetN = 1'b0;
  logic        Enable = 1'b0;
  logic        SerIn  = 1'b0;
  logic [3:0]  ChipAddr = 4'd0;
  logic        RdEn   = 1'b0;
  logic        ClrErr = 1'b0;
  logic [11:0] Dout;
  logic        Valid, Full, Busy, FrameDone, Overflow, ParErr, AddrErr;

  int checks = 0;
  int passed = 0;
  int fdCount = 0;

  always #5 SysCLK = ~SysCLK;

  asic_data_rx #(.DEPTH(16)) dut (
    .SysCLK(SysCLK), .ResetN(ResetN), .Enable(Enable), .SerIn(SerIn),
    .ChipAddr(ChipAddr), .RdEn(RdEn), .ClrErr(ClrErr), .Dout(Dout),
    .Valid(Valid), .Full(Full), .Busy(Busy), .FrameDone(FrameDone),
    .Overflow(Overflow), .ParErr(ParErr), .AddrErr(AddrErr)
  );

  always @(negedge SysCLK) if (FrameDone === 1'b1) fdCount++;

  task automatic startBit;
    @(negedge SysCLK); SerIn = 1'b1;
  endtask

  task automatic sendWord(input logic [11:0] w);
    for (int i = 11; i >= 0; i--) begin
      @(negedge SysCLK); SerIn = w[i];
    end
`ifdef ASIC_RX_PARITY_EN
    @(negedge SysCLK); SerIn = ~(^w);
`endif
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge SysCLK); SerIn = 1'b0;
    end
  endtask

  task automatic popWord(output logic [11:0] w, output logic v);
    @(negedge SysCLK);
    v = Valid; w = Dout;
    RdEn = 1'b1;
    @(negedge SysCLK);
    RdEn = 1'b0;
  endtask

  task automatic sendFullFrame(input logic [11:0] hdr, input logic [11:0] base);
    startBit();
    sendWord(hdr);
    for (int i = 0; i < 15; i++) sendWord(base + 12'(i));
  endtask

  task automatic test_reset;
    ResetN = 1'b0;
    repeat (3) @(negedge SysCLK);
    checks++;
    if ({Dout, Valid, Full, Busy, FrameDone, Overflow, ParErr, AddrErr} !== 19'd0)
      $display("FAIL reset_outputs: got %h required 0",
               {Dout, Valid, Full, Busy, FrameDone, Overflow, ParErr, AddrErr});
    else passed++;
    ResetN = 1'b1;
    idle(2);
    checks++;
    if (Busy !== 1'b0 || Valid !== 1'b0)
      $display("FAIL reset_release: Busy=%b Valid=%b required 0 0", Busy, Valid);
    else passed++;
  endtask

  task automatic test_n0;
    logic [11:0] w; logic v; int fd0;
    ChipAddr = 4'd3;
    Enable = 1'b0;
    @(negedge SysCLK); SerIn = 1'b1;
    @(negedge SysCLK); SerIn = 1'b0;
    @(posedge SysCLK); #1;
    checks++;
    if (Busy !== 1'b0) $display("FAIL enable_gate: Busy=%b required 0", Busy);
    else passed++;
    Enable = 1'b1;
    idle(2);
    fd0 = fdCount;
    startBit();
    @(posedge SysCLK); #1;
    checks++;
    if (Busy !== 1'b1) $display("FAIL busy_after_start: Busy=%b required 1", Busy);
    else passed++;
    sendWord(12'h302);
    @(posedge SysCLK); #1; SerIn = 1'b0;
    checks++;
    if (FrameDone !== 1'b1 || Valid !== 1'b0 || Busy !== 1'b0)
      $display("FAIL n0_write_edge: FrameDone=%b Valid=%b Busy=%b required 1 0 0",
               FrameDone, Valid, Busy);
    else passed++;
    @(posedge SysCLK); #1;
    checks++;
    if (Valid !== 1'b1 || Dout !== 12'h302 || FrameDone !== 1'b0)
      $display("FAIL n0_valid_edge: Valid=%b Dout=%h FrameDone=%b required 1 302 0",
               Valid, Dout, FrameDone);
    else passed++;
    idle(2);
    popWord(w, v);
    checks++;
    if (v !== 1'b1 || w !== 12'h302) $display("FAIL n0_word: got %b/%h required 1/302", v, w);
    else passed++;
    @(negedge SysCLK);
    checks++;
    if (Valid !== 1'b0 || fdCount - fd0 != 1)
      $display("FAIL n0_single: Valid=%b frames=%0d required 0 1", Valid, fdCount - fd0);
    else passed++;
    checks++;
    if ({Overflow, ParErr, AddrErr} !== 3'b000)
      $display("FAIL n0_no_errors: got %b required 000", {Overflow, ParErr, AddrErr});
    else passed++;
  endtask

  task automatic test_back_to_back;
    logic [11:0] w; logic v; int fd0;
    logic [11:0] exp [6];
    exp = '{12'h330, 12'h041, 12'h0C5, 12'hFFF, 12'h31C, 12'h123};
    ChipAddr = 4'd3;
    fd0 = fdCount;
    startBit();
    for (int i = 0; i < 4; i++) sendWord(exp[i]);
    startBit();
    sendWord(exp[4]);
    sendWord(exp[5]);
    idle(3);
    for (int i = 0; i < 6; i++) begin
      popWord(w, v);
      checks++;
      if (v !== 1'b1 || w !== exp[i])
        $display("FAIL b2b_word%0d: got %b/%h required 1/%h", i, v, w, exp[i]);
      else passed++;
    end
    checks++;
    if (Valid !== 1'b0 || fdCount - fd0 != 2)
      $display("FAIL b2b_frames: Valid=%b frames=%0d required 0 2", Valid, fdCount - fd0);
    else passed++;
  endtask

  task automatic test_addr_err;
    logic [11:0] w; logic v;
    ChipAddr = 4'd2;
    startBit();
    sendWord(12'h500);
    idle(3);
    checks++;
    if (AddrErr !== 1'b1) $display("FAIL addr_err_set: AddrErr=%b required 1", AddrErr);
    else passed++;
    popWord(w, v);
    checks++;
    if (v !== 1'b1 || w !== 12'h500) $display("FAIL addr_err_kept: got %b/%h required 1/500", v, w);
    else passed++;
    @(negedge SysCLK); ClrErr = 1'b1;
    @(negedge SysCLK); ClrErr = 1'b0;
    checks++;
    if (AddrErr !== 1'b0) $display("FAIL addr_err_clear: AddrErr=%b required 0", AddrErr);
    else passed++;
    startBit();
    sendWord(12'h500);
    ClrErr = 1'b1;
    @(posedge SysCLK); #1; ClrErr = 1'b0; SerIn = 1'b0;
    checks++;
    if (AddrErr !== 1'b1) $display("FAIL clr_vs_set: AddrErr=%b required 1", AddrErr);
    else passed++;
    idle(3);
    popWord(w, v);
    @(negedge SysCLK); ClrErr = 1'b1;
    @(negedge SysCLK); ClrErr = 1'b0;
    checks++;
    if (AddrErr !== 1'b0 || Valid !== 1'b0 || w !== 12'h500)
      $display("FAIL addr_err_final: AddrErr=%b Valid=%b word=%h required 0 0 500", AddrErr, Valid, w);
    else passed++;
  endtask

  task automatic test_overflow;
    logic [11:0] w; logic v;
    ChipAddr = 4'd1;
    sendFullFrame(12'h1F0, 12'h100);
    idle(3);
    checks++;
    if (Full !== 1'b1 || Overflow !== 1'b0)
      $display("FAIL ovf_full16: Full=%b Overflow=%b required 1 0", Full, Overflow);
    else passed++;
    startBit();
    sendWord(12'h104);
    @(negedge SysCLK); SerIn = 1'b0;
    w = Dout;
    RdEn = 1'b1;
    @(negedge SysCLK); RdEn = 1'b0;
    checks++;
    if (w !== 12'h1F0 || Full !== 1'b1 || Overflow !== 1'b0 || Dout !== 12'h100)
      $display("FAIL ovf_pop_and_write: head=%h Full=%b Overflow=%b Dout=%h required 1f0 1 0 100",
               w, Full, Overflow, Dout);
    else passed++;
    sendFullFrame(12'h1F0, 12'h200);
    idle(3);
    checks++;
    if (Full !== 1'b1 || Overflow !== 1'b1)
      $display("FAIL ovf_set: Full=%b Overflow=%b required 1 1", Full, Overflow);
    else passed++;
    for (int i = 0; i < 16; i++) begin
      logic [11:0] e;
      e = (i < 15) ? 12'h100 + 12'(i) : 12'h104;
      popWord(w, v);
      checks++;
      if (v !== 1'b1 || w !== e) $display("FAIL ovf_drain%0d: got %b/%h required 1/%h", i, v, w, e);
      else passed++;
    end
    checks++;
    if (Valid !== 1'b0 || Full !== 1'b0)
      $display("FAIL ovf_empty: Valid=%b Full=%b required 0 0", Valid, Full);
    else passed++;
    startBit();
    sendWord(12'h12C);
    sendWord(12'h3AA);
    sendWord(12'h055);
    idle(3);
    popWord(w, v);
    checks++;
    if (v !== 1'b1 || w !== 12'h12C) $display("FAIL ovf_next_hdr: got %b/%h required 1/12c", v, w);
    else passed++;
    popWord(w, v);
    checks++;
    if (v !== 1'b1 || w !== 12'h3AA) $display("FAIL ovf_next_c1: got %b/%h required 1/3aa", v, w);
    else passed++;
    popWord(w, v);
    checks++;
    if (v !== 1'b1 || w !== 12'h055 || AddrErr !== 1'b0)
      $display("FAIL ovf_next_c2: got %b/%h AddrErr=%b required 1/055 0", v, w, AddrErr);
    else passed++;
  endtask

  task automatic test_reset_mid;
    logic [11:0] w; logic v; logic [11:0] part;
    part = 12'h0C5;
    ChipAddr = 4'd3;
    startBit();
    sendWord(12'h320);
    sendWord(12'h041);
    for (int i = 11; i >= 7; i--) begin
      @(negedge SysCLK); SerIn = part[i];
    end
    checks++;
    if (Valid !== 1'b1 || Busy !== 1'b1 || Overflow !== 1'b1)
      $display("FAIL pre_reset_state: Valid=%b Busy=%b Overflow=%b required 1 1 1", Valid, Busy, Overflow);
    else passed++;
    @(negedge SysCLK); ResetN = 1'b0; SerIn = 1'b0;
    #1;
    checks++;
    if ({Dout, Valid, Full, Busy, FrameDone, Overflow, ParErr, AddrErr} !== 19'd0)
      $display("FAIL reset_mid_outputs: got %h required 0",
               {Dout, Valid, Full, Busy, FrameDone, Overflow, ParErr, AddrErr});
    else passed++;
    repeat (2) @(negedge SysCLK);
    ResetN = 1'b1;
    idle(10);
    startBit();
    sendWord(12'h310);
    sendWord(12'h7E5);
    idle(3);
    popWord(w, v);
    checks++;
    if (v !== 1'b1 || w !== 12'h310) $display("FAIL post_reset_hdr: got %b/%h required 1/310", v, w);
    else passed++;
    popWord(w, v);
    checks++;
    if (v !== 1'b1 || w !== 12'h7E5 || Valid !== 1'b0)
      $display("FAIL post_reset_clus: got %b/%h Valid=%b required 1/7e5 0", v, w, Valid);
    else passed++;
  endtask

`ifdef ASIC_RX_PARITY_EN
  task automatic sendBadWord(input logic [11:0] w);
    for (int i = 11; i >= 0; i--) begin
      @(negedge SysCLK); SerIn = w[i];
    end
    @(negedge SysCLK); SerIn = ^w;
  endtask

  task automatic test_parity;
    logic [11:0] w; logic v;
    logic [11:0] exp [3];
    exp = '{12'h310, 12'h0F1, 12'h300};
    ChipAddr = 4'd3;
    checks++;
    if (ParErr !== 1'b0) $display("FAIL par_clean: ParErr=%b required 0", ParErr);
    else passed++;
    startBit();
    sendWord(exp[0]);
    sendBadWord(exp[1]);
    startBit();
    sendWord(exp[2]);
    @(posedge SysCLK); #1; SerIn = 1'b0;
    checks++;
    if (FrameDone !== 1'b1) $display("FAIL par_next_timing: FrameDone=%b required 1", FrameDone);
    else passed++;
    idle(3);
    checks++;
    if (ParErr !== 1'b1) $display("FAIL par_err_set: ParErr=%b required 1", ParErr);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      popWord(w, v);
      checks++;
      if (v !== 1'b1 || w !== exp[i])
        $display("FAIL par_word%0d: got %b/%h required 1/%h", i, v, w, exp[i]);
      else passed++;
    end
  endtask
`else
  task automatic test_parity;
    ChipAddr = 4'd3;
    startBit();
    sendWord(12'h3F1);
    idle(3);
    checks++;
    if (ParErr !== 1'b0 || Valid !== 1'b1)
      $display("FAIL par_tied: ParErr=%b Valid=%b required 0 1", ParErr, Valid);
    else passed++;
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_n0();
    test_back_to_back();
    test_addr_err();
    test_overflow();
    test_reset_mid();
    test_parity();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
